// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: ALU op encodings, FSM states and default widths.
package ex_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;

  typedef enum logic [1:0] {
    EX_ADD = 2'b00,
    EX_SUB = 2'b01,
    EX_ORI = 2'b10,
    EX_MUL = 2'b11
  } ex_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle seen by the execute stage; master is the pipeline side, slave is ex_stage.
interface ex_stage_if import ex_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic [DATA_W-1:0] in_zext_imd;
  logic [DATA_W-1:0] in_sext_imd;
  logic [REG_W-1:0]  in_src_reg;
  logic [REG_W-1:0]  in_dst_reg;
  logic              in_wb;
  logic              in_mem;
  logic [1:0]        in_ex;
  logic              flush;
  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_result_hi;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_src_reg;
  logic [REG_W-1:0]  out_dst_reg;
  logic              out_wb;
  logic              out_mem;

  modport master (
    output in_valid, in_op1, in_op2, in_zext_imd, in_sext_imd, in_src_reg, in_dst_reg,
           in_wb, in_mem, in_ex, flush,
    input  stall, out_valid, out_result, out_result_hi, out_store_data, out_src_reg,
           out_dst_reg, out_wb, out_mem
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_zext_imd, in_sext_imd, in_src_reg, in_dst_reg,
           in_wb, in_mem, in_ex, flush,
    output stall, out_valid, out_result, out_result_hi, out_store_data, out_src_reg,
           out_dst_reg, out_wb, out_mem
  );

endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per product.
module mul_iter import ex_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                kill_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] accSum;

  // The final step's sum is exposed combinationally so the caller can register it on the same edge.
  always_comb begin
    accSum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign product_o = accSum;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= accSum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= done_o ? '0 : cnt_q + 1'b1;
      busy_q   <= !done_o;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle add/sub/ori/address generation, iterative multiply with upstream stall.
module ex_stage import ex_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  ex_state_e state_q, state_d;

  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outResult_q, outResult_d;
  logic [DATA_W-1:0] outResultHi_q, outResultHi_d;
  logic [DATA_W-1:0] outStore_q, outStore_d;
  logic [REG_W-1:0]  outSrc_q, outSrc_d;
  logic [REG_W-1:0]  outDst_q, outDst_d;
  logic              outWb_q, outWb_d;
  logic              outMem_q, outMem_d;

  logic [DATA_W-1:0] pendStore_q, pendStore_d;
  logic [REG_W-1:0]  pendSrc_q, pendSrc_d;
  logic [REG_W-1:0]  pendDst_q, pendDst_d;
  logic              pendWb_q, pendWb_d;
  logic              pendMem_q, pendMem_d;

  logic                mulStart;
  logic                mulBusy;
  logic                mulDone;
  logic [2*DATA_W-1:0] mulProduct;
  logic                accept;
  ex_op_e              op;

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mulStart),
    .kill_i    (bus.flush),
    .a_i       (bus.in_op1),
    .b_i       (bus.in_op2),
    .busy_o    (mulBusy),
    .done_o    (mulDone),
    .product_o (mulProduct)
  );

  assign op     = ex_op_e'(bus.in_ex);
  assign accept = (state_q == S_IDLE) && bus.in_valid && !bus.flush;

  // Outputs hold by default; out_valid pulses only on an accept or a multiply completion.
  always_comb begin
    state_d       = state_q;
    outValid_d    = 1'b0;
    outResult_d   = outResult_q;
    outResultHi_d = outResultHi_q;
    outStore_d    = outStore_q;
    outSrc_d      = outSrc_q;
    outDst_d      = outDst_q;
    outWb_d       = outWb_q;
    outMem_d      = outMem_q;
    pendStore_d   = pendStore_q;
    pendSrc_d     = pendSrc_q;
    pendDst_d     = pendDst_q;
    pendWb_d      = pendWb_q;
    pendMem_d     = pendMem_q;
    mulStart      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!bus.in_mem && op == EX_MUL) begin
            mulStart    = 1'b1;
            state_d     = S_MUL;
            pendStore_d = bus.in_op2;
            pendSrc_d   = bus.in_src_reg;
            pendDst_d   = bus.in_dst_reg;
            pendWb_d    = bus.in_wb;
            pendMem_d   = bus.in_mem;
          end else begin
            outValid_d    = 1'b1;
            outResultHi_d = '0;
            outStore_d    = bus.in_op2;
            outSrc_d      = bus.in_src_reg;
            outDst_d      = bus.in_dst_reg;
            outWb_d       = bus.in_wb;
            outMem_d      = bus.in_mem;
            if (bus.in_mem) begin
              outResult_d = bus.in_op1 + bus.in_sext_imd;
            end else begin
              case (op)
                EX_ADD:  outResult_d = bus.in_op1 + bus.in_op2;
                EX_SUB:  outResult_d = bus.in_op1 - bus.in_op2;
                EX_ORI:  outResult_d = bus.in_op1 | bus.in_zext_imd;
                default: outResult_d = '0;
              endcase
            end
          end
        end
      end
      S_MUL: begin
        // Falling out of MUL without a done is a recovery path only; normal exits are flush or done.
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (mulDone) begin
          state_d       = S_IDLE;
          outValid_d    = 1'b1;
          outResult_d   = mulProduct[DATA_W-1:0];
          outResultHi_d = mulProduct[2*DATA_W-1:DATA_W];
          outStore_d    = pendStore_q;
          outSrc_d      = pendSrc_q;
          outDst_d      = pendDst_q;
          outWb_d       = pendWb_q;
          outMem_d      = pendMem_q;
        end else if (!mulBusy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      outValid_q    <= 1'b0;
      outResult_q   <= '0;
      outResultHi_q <= '0;
      outStore_q    <= '0;
      outSrc_q      <= '0;
      outDst_q      <= '0;
      outWb_q       <= 1'b0;
      outMem_q      <= 1'b0;
      pendStore_q   <= '0;
      pendSrc_q     <= '0;
      pendDst_q     <= '0;
      pendWb_q      <= 1'b0;
      pendMem_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      outValid_q    <= outValid_d;
      outResult_q   <= outResult_d;
      outResultHi_q <= outResultHi_d;
      outStore_q    <= outStore_d;
      outSrc_q      <= outSrc_d;
      outDst_q      <= outDst_d;
      outWb_q       <= outWb_d;
      outMem_q      <= outMem_d;
      pendStore_q   <= pendStore_d;
      pendSrc_q     <= pendSrc_d;
      pendDst_q     <= pendDst_d;
      pendWb_q      <= pendWb_d;
      pendMem_q     <= pendMem_d;
    end
  end

  assign bus.stall          = (state_q == S_MUL);
  assign bus.out_valid      = outValid_q;
  assign bus.out_result     = outResult_q;
  assign bus.out_result_hi  = outResultHi_q;
  assign bus.out_store_data = outStore_q;
  assign bus.out_src_reg    = outSrc_q;
  assign bus.out_dst_reg    = outDst_q;
  assign bus.out_wb         = outWb_q;
  assign bus.out_mem        = outMem_q;

endmodule
